// File: rtl/regbus_arbiter_pkg.sv
// regbus_arbiter shared types and constants.
// States, bus widths and the timeout read-data value.
package regbus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/regbus_arbiter_rr_picker.sv
// Round-robin picker: first requester after last, with wrap.
// Purely combinational, parameterised by N.
module rr_picker
  import regbus_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regbus_arbiter.sv
// Round-robin register-bus arbiter, one transaction in flight.
// Define REGBUS_ARBITER_TIMEOUT_EN to add the BUSY timeout.
module regbus_arbiter
  import regbus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_MASTERS-1:0]     m_valid,
  output logic [NUM_MASTERS-1:0]     m_ready,
  input  logic [4*NUM_MASTERS-1:0]   m_wstrb,
  input  logic [32*NUM_MASTERS-1:0]  m_addr,
  input  logic [32*NUM_MASTERS-1:0]  m_wdata,
  output logic [31:0]                m_rdata,
  output logic                       s_valid,
  input  logic                       s_ready,
  output logic [3:0]                 s_wstrb,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic [31:0]                s_rdata,
`ifdef REGBUS_ARBITER_TIMEOUT_EN
  output logic                       timeout_err,
`endif
  output logic [NUM_MASTERS-1:0]     grant
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = $clog2(N);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("NUM_MASTERS must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_t
    $error("TIMEOUT_CYCLES must be 1..65535");
  end

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_last;
  logic [N-1:0]    r_grant;
  logic            r_s_valid;
  logic [31:0]     r_rdata;
  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic            w_busy;
  logic            w_done;
  logic            w_tmo;
  logic            w_end;
  logic            w_own;

  rr_picker #(.N(N), .IW(IW)) u_pick (
    .req   (m_valid),
    .last  (r_last),
    .found (w_found),
    .idx   (w_pick)
  );

  assign w_busy = (r_state == BUSY);
  assign w_own  = m_valid[r_last];
  assign w_done = w_busy & s_ready & ~reset;

`ifdef REGBUS_ARBITER_TIMEOUT_EN
  logic [15:0] r_cnt;

  assign w_tmo = w_busy & ~s_ready & ~reset
               & (r_cnt == 16'(TIMEOUT_CYCLES - 1));
  assign timeout_err = w_tmo;

  // BUSY cycle counter, cleared while waiting in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if (w_busy && r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign w_end = w_done | w_tmo;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_next = BUSY;
      BUSY:    if (w_end || !w_own) w_next = RECOVER;
      RECOVER: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, owner, registered valid and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last    <= IW'(N - 1);
      r_grant   <= '0;
      r_s_valid <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_next;
      r_s_valid <= (w_next == BUSY);
      if (r_state == IDLE && w_found) begin
        r_grant <= N'(1) << w_pick;
        r_last  <= w_pick;
      end else if (w_next != BUSY) begin
        r_grant <= '0;
      end
      if (w_done) begin
        r_rdata <= s_rdata;
      end else if (w_tmo) begin
        r_rdata <= TIMEOUT_RDATA;
      end
    end
  end

  assign grant   = r_grant;
  assign s_valid = r_s_valid;
  assign m_ready = w_end ? r_grant : '0;
  assign m_rdata = w_done ? s_rdata
                 : w_tmo  ? TIMEOUT_RDATA
                 : r_rdata;

  // Payload follows the owner; zero outside BUSY.
  always_comb begin
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (w_busy) begin
      s_wstrb = m_wstrb[int'(r_last)*STRB_W +: STRB_W];
      s_addr  = m_addr[int'(r_last)*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[int'(r_last)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter with a completion scoreboard.
// Define REGBUS_ARBITER_TIMEOUT_EN to also run the timeout steps.
module tb_regbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_valid;
  logic [1:0]  m_ready;
  logic [7:0]  m_wstrb;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [31:0] m_rdata;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
`ifdef REGBUS_ARBITER_TIMEOUT_EN
  logic        timeout_err;
`endif

  regbus_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_wstrb (m_wstrb),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_wstrb (s_wstrb),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
`ifdef REGBUS_ARBITER_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .grant   (grant)
  );

  always #5 clk = ~clk;

  // Slave: ready is a registered copy of valid, or stuck high.
  logic r_sr = 1'b0;
  logic stuck;
  logic slave_en;
  always @(posedge clk) r_sr <= s_valid & slave_en;
  assign s_ready = stuck | r_sr;
  assign s_rdata = s_addr ^ 32'h1234_5678;

  localparam logic [31:0] A0 = 32'h0000_0000;
  localparam logic [31:0] A1 = 32'h0000_0010;
  localparam logic [31:0] D0 = 32'h0000_0001;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;
  localparam logic [3:0]  S0 = 4'h1;
  localparam logic [3:0]  S1 = 4'hF;

  typedef struct {
    int          idx;
    logic [31:0] rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  st;
  } exp_t;

  exp_t sbq[$];
  int   cmp = 0;
  int   bad = 0;
  int   n_done = 0;
  bit   started = 0;
  logic [1:0] prev_rdy = 2'b00;

  function automatic exp_t mk(int i, bit tmo);
    exp_t e;
    e.idx  = i;
    e.addr = (i == 0) ? A0 : A1;
    e.wd   = (i == 0) ? D0 : D1;
    e.st   = (i == 0) ? S0 : S1;
    e.rd   = tmo ? 32'hFFFF_FFFF : (e.addr ^ 32'h1234_5678);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every completion pops one expected transaction.
  always @(negedge clk) begin
    if (started && m_ready !== 2'b00) begin
      if (sbq.size() == 0) begin
        cmp++;
        bad++;
        $error("FAIL unexpected_rdy: observed %b expected 00", m_ready);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_rdy",   32'(m_ready), 32'(2'b01 << e.idx));
        chk("sb_rdata", m_rdata, e.rd);
        chk("sb_addr",  s_addr,  e.addr);
        chk("sb_wdata", s_wdata, e.wd);
        chk("sb_wstrb", 32'(s_wstrb), 32'(e.st));
        chk("sb_pulse", 32'(prev_rdy), 32'd0);
      end
      n_done++;
    end
    prev_rdy = started ? m_ready : 2'b00;
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(int target);
    for (int c = 0; c < 100 && n_done < target; c++) @(negedge clk);
    cmp++;
    assert (n_done >= target) else begin
      bad++;
      $error("FAIL wait_done: observed %0d expected %0d", n_done, target);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed hang expected finish");
    $fatal(1);
  end

  initial begin
    m_valid  = 2'b00;
    m_addr   = {A1, A0};
    m_wdata  = {D1, D0};
    m_wstrb  = {S1, S0};
    stuck    = 1'b0;
    slave_en = 1'b1;
    do_reset();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_rdy",   32'(m_ready), 0);
    chk("rst_sval",  32'(s_valid), 0);
    chk("rst_addr",  s_addr, 0);
    chk("rst_strb",  32'(s_wstrb), 0);
    chk("rst_rdata", m_rdata, 0);
    started = 1;

    // Single master, cycle-exact latency.
    sbq.push_back(mk(0, 0));
    m_valid = 2'b01;
    nx();
    chk("t1_c1_sval",  32'(s_valid), 1);
    chk("t1_c1_grant", 32'(grant), 1);
    chk("t1_c1_rdy",   32'(m_ready), 0);
    nx();
    chk("t1_c2_sval",  32'(s_valid), 1);
    chk("t1_c2_rdy",   32'(m_ready), 1);
    chk("t1_c2_rdata", m_rdata, 32'h1234_5678);
    m_valid = 2'b00;
    nx();
    chk("t1_c3_grant", 32'(grant), 0);
    chk("t1_c3_sval",  32'(s_valid), 0);
    chk("t1_c3_rdy",   32'(m_ready), 0);
    nx();
    chk("t1_c4_sval",  32'(s_valid), 0);
    repeat (2) nx();

    // Two masters holding: strict alternation.
    do_reset();
    sbq.push_back(mk(0, 0));
    sbq.push_back(mk(1, 0));
    sbq.push_back(mk(0, 0));
    sbq.push_back(mk(1, 0));
    m_valid = 2'b11;
    wait_done(n_done + 4);
    m_valid = 2'b00;
    repeat (4) nx();
    chk("t2_drain", 32'(sbq.size()), 0);

    // Ready stuck high: RECOVER ignores it.
    do_reset();
    stuck = 1'b1;
    sbq.push_back(mk(0, 0));
    sbq.push_back(mk(1, 0));
    m_valid = 2'b11;
    nx();
    chk("t3_c1_rdy",   32'(m_ready), 1);
    m_valid = 2'b10;
    nx();
    chk("t3_rec_rdy",  32'(m_ready), 0);
    chk("t3_rec_gnt",  32'(grant), 0);
    chk("t3_rec_sval", 32'(s_valid), 0);
    nx();
    chk("t3_idle_rdy", 32'(m_ready), 0);
    chk("t3_idle_gnt", 32'(grant), 0);
    nx();
    chk("t3_b1_gnt",   32'(grant), 2);
    chk("t3_b1_rdy",   32'(m_ready), 2);
    m_valid = 2'b00;
    nx();
    chk("t3_after",    32'(m_ready), 0);
    stuck = 1'b0;
    repeat (3) nx();

    // Master 1 abandons in BUSY.
    do_reset();
    slave_en = 1'b0;
    m_valid = 2'b10;
    nx();
    chk("t4_gnt",   32'(grant), 2);
    chk("t4_sval",  32'(s_valid), 1);
    m_valid = 2'b00;
    nx();
    chk("t4_rec_sval", 32'(s_valid), 0);
    chk("t4_rec_gnt",  32'(grant), 0);
    chk("t4_rec_rdy",  32'(m_ready), 0);
    nx();
    chk("t4_idle_sval", 32'(s_valid), 0);
    slave_en = 1'b1;
    sbq.push_back(mk(0, 0));
    m_valid = 2'b01;
    nx();
    chk("t4_next_gnt", 32'(grant), 1);
    wait_done(n_done + 1);
    m_valid = 2'b00;
    repeat (3) nx();

    // Reset while BUSY with a stalled slave.
    slave_en = 1'b0;
    m_valid = 2'b10;
    nx();
    chk("t5_gnt", 32'(grant), 2);
    reset = 1'b1;
    nx();
    chk("t5_gnt0",  32'(grant), 0);
    chk("t5_sval",  32'(s_valid), 0);
    chk("t5_rdy",   32'(m_ready), 0);
    chk("t5_rdata", m_rdata, 0);
    chk("t5_addr",  s_addr, 0);
    reset = 1'b0;
    slave_en = 1'b1;
    sbq.push_back(mk(0, 0));
    m_valid = 2'b11;
    nx();
    chk("t5_first", 32'(grant), 1);
    wait_done(n_done + 1);
    m_valid = 2'b00;
    repeat (4) nx();

`ifdef REGBUS_ARBITER_TIMEOUT_EN
    // Slave never ready: timeout on BUSY cycle 4.
    do_reset();
    slave_en = 1'b0;
    sbq.push_back(mk(0, 1));
    sbq.push_back(mk(1, 1));
    m_valid = 2'b11;
    repeat (3) nx();
    chk("t6_c3_err", 32'(timeout_err), 0);
    chk("t6_c3_rdy", 32'(m_ready), 0);
    nx();
    chk("t6_c4_err",   32'(timeout_err), 1);
    chk("t6_c4_rdy",   32'(m_ready), 1);
    chk("t6_c4_rdata", m_rdata, 32'hFFFF_FFFF);
    m_valid = 2'b10;
    wait_done(n_done + 1);
    m_valid = 2'b00;
    repeat (4) nx();
    slave_en = 1'b1;
`endif

    chk("final_drain", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
